// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Iterative unsigned restoring divider, one quotient bit per clock,
//            with start/done handshake and divide-by-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] A,
    input  logic [VW-1:0] B,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          done,
    output logic          busy,
    output logic          div_by_zero
);

    localparam int            CW     = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [1:0]    c_idle = 2'd0;
    localparam logic [1:0]    c_run  = 2'd1;
    localparam logic [1:0]    c_done = 2'd2;
    localparam logic [CW-1:0] c_last = CW'(DW - 1);

    logic [1:0]    r_state,     w_state_nxt;
    logic [CW-1:0] r_count,     w_count_nxt;
    logic [VW:0]   r_p,         w_p_nxt;
    logic [DW-1:0] r_shift,     w_shift_nxt;
    logic [VW-1:0] r_dvs,       w_dvs_nxt;
    logic [DW-1:0] r_quotient,  w_quotient_nxt;
    logic [VW-1:0] r_remainder, w_remainder_nxt;
    logic          r_done,      w_done_nxt;
    logic          r_busy,      w_busy_nxt;
    logic          r_dbz,       w_dbz_nxt;

    logic [VW:0]   w_p_shift;
    logic [VW:0]   w_p_diff;
    logic          w_ge;
    logic [VW:0]   w_p_step;
    logic [DW-1:0] w_shift_step;

    // The dividend register doubles as the quotient register: dividend bits
    // leave at the MSB while quotient bits enter at the LSB.
    assign w_p_shift    = (VW+1)'({r_p, r_shift} >> (DW - 1));
    assign w_p_diff     = w_p_shift - {1'b0, r_dvs};
    assign w_ge         = (w_p_shift >= {1'b0, r_dvs});
    assign w_p_step     = w_ge ? w_p_diff : w_p_shift;
    assign w_shift_step = {r_shift[DW-2:0], w_ge};

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_p_nxt         = r_p;
        w_shift_nxt     = r_shift;
        w_dvs_nxt       = r_dvs;
        w_quotient_nxt  = r_quotient;
        w_remainder_nxt = r_remainder;
        w_dbz_nxt       = r_dbz;

        case (r_state)
            c_idle: begin
                if (start) begin
                    w_shift_nxt = A;
                    w_dvs_nxt   = B;
                    w_p_nxt     = '0;
                    w_count_nxt = '0;
                    if (B != '0) begin
                        w_state_nxt = c_run;
                    end else begin
                        w_state_nxt     = c_done;
                        w_quotient_nxt  = '1;
                        w_remainder_nxt = '0;
                        w_dbz_nxt       = 1'b1;
                    end
                end
            end
            c_run: begin
                w_p_nxt     = w_p_step;
                w_shift_nxt = w_shift_step;
                w_count_nxt = r_count + CW'(1);
                if (r_count == c_last) begin
                    w_state_nxt     = c_done;
                    w_quotient_nxt  = w_shift_step;
                    w_remainder_nxt = w_p_step[VW-1:0];
                    w_dbz_nxt       = 1'b0;
                end
            end
            c_done: begin
                w_state_nxt = c_idle;
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase

        w_done_nxt = (w_state_nxt == c_done);
        w_busy_nxt = (w_state_nxt != c_idle);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_idle;
            r_count     <= '0;
            r_p         <= '0;
            r_shift     <= '0;
            r_dvs       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_p         <= w_p_nxt;
            r_shift     <= w_shift_nxt;
            r_dvs       <= w_dvs_nxt;
            r_quotient  <= w_quotient_nxt;
            r_remainder <= w_remainder_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
            r_dbz       <= w_dbz_nxt;
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign done        = r_done;
    assign busy        = r_busy;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Self-checking bench for seq_divider against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] A;
    logic [7:0]  B;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        done;
    logic        busy;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    seq_divider #(.DW(16), .VW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .A           (A),
        .B           (B),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division; B==0 saturates the quotient.
    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic z);
        if (b == 8'd0) begin
            q = 16'hFFFF; r = 8'd0; z = 1'b1;
        end else begin
            q = 16'(int'(a) / int'(b));
            r = 8'(int'(a) % int'(b));
            z = 1'b0;
        end
    endfunction

    // Issues one single-cycle start pulse; lat counts edges from acceptance
    // to the first sample showing done.
    task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                         output int lat, output int busy_cyc);
        @(negedge clk); A = a; B = b; start = 1'b1;
        @(negedge clk); start = 1'b0;
        lat = 1;
        busy_cyc = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) busy_cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({quotient, remainder, done, busy, div_by_zero} !== 27'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got q=%0d r=%0d done=%b busy=%b dbz=%b, want all 0",
                     quotient, remainder, done, busy, div_by_zero);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, bc;
        do_op(16'd1000, 8'd7, lat, bc);
        n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL basic_latency: got %0d want 17", lat); end
        n_cmp++; if (quotient !== 16'd142) begin n_err++; $display("FAIL basic_quotient: got %0d want 142", quotient); end
        n_cmp++; if (remainder !== 8'd6) begin n_err++; $display("FAIL basic_remainder: got %0d want 6", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL basic_dbz: got %b want 0", div_by_zero); end
        n_cmp++; if (bc !== 17) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 17", bc); end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_one_cycle: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_vectors;
        logic [15:0] va [3] = '{16'd65535, 16'd100, 16'd255};
        logic [7:0]  vb [3] = '{8'd255, 8'd200, 8'd1};
        logic [15:0] eq; logic [7:0] er; logic ez;
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            model(va[i], vb[i], eq, er, ez);
            do_op(va[i], vb[i], lat, bc);
            n_cmp++;
            if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                n_err++;
                $display("FAIL vector_%0d: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                         i, quotient, remainder, div_by_zero, eq, er, ez);
            end
        end
        A = 16'd9; B = 8'd4;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (quotient !== 16'd255 || remainder !== 8'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_hold: got q=%0d r=%0d busy=%b want q=255 r=0 busy=0",
                     quotient, remainder, busy);
        end
    endtask

    task automatic test_div_zero;
        int lat, bc;
        do_op(16'd1234, 8'd0, lat, bc);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_cmp++;
        if (quotient !== 16'hFFFF || remainder !== 8'd0 || div_by_zero !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL dz_result: got q=%0d r=%0d z=%b busy=%b want q=65535 r=0 z=1 busy=1",
                     quotient, remainder, div_by_zero, busy);
        end
        do_op(16'd10, 8'd3, lat, bc);
        n_cmp++;
        if (quotient !== 16'd3 || remainder !== 8'd1 || div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL dz_recover: got q=%0d r=%0d z=%b want q=3 r=1 z=0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_start_while_busy;
        int lat;
        @(negedge clk); A = 16'd500; B = 8'd9; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        A = 16'd7; B = 8'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        lat = 6;
        while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL busy_start_latency: got %0d want 17", lat); end
        n_cmp++;
        if (quotient !== 16'd55 || remainder !== 8'd5) begin
            n_err++;
            $display("FAIL busy_start_result: got q=%0d r=%0d want q=55 r=5", quotient, remainder);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL busy_start_not_queued: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_run;
        int lat, bc, seen;
        @(negedge clk); A = 16'd500; B = 8'd9; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        n_cmp++;
        if ({quotient, remainder, done, busy, div_by_zero} !== 27'd0) begin
            n_err++;
            $display("FAIL midrun_reset: got q=%0d r=%0d done=%b busy=%b dbz=%b want all 0",
                     quotient, remainder, done, busy, div_by_zero);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL midrun_no_done: got %0d active samples want 0", seen); end
        do_op(16'd20, 8'd6, lat, bc);
        n_cmp++;
        if (quotient !== 16'd3 || remainder !== 8'd2 || lat !== 17) begin
            n_err++;
            $display("FAIL midrun_fresh_op: got q=%0d r=%0d lat=%0d want q=3 r=2 lat=17",
                     quotient, remainder, lat);
        end
    endtask

    task automatic test_back_to_back;
        int gap, idle, w;
        @(negedge clk); A = 16'd13; B = 8'd5; start = 1'b1;
        w = 0;
        while (done !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        n_cmp++; if (w >= 40) begin n_err++; $display("FAIL b2b_first_done: got timeout want done"); end
        for (int k = 0; k < 3; k++) begin
            gap = 0; idle = 0;
            do begin
                @(negedge clk);
                gap++;
                if (busy === 1'b0) idle++;
            end while (done !== 1'b1 && gap < 40);
            n_cmp++;
            if (gap !== 18 || idle !== 1 || quotient !== 16'd2 || remainder !== 8'd3) begin
                n_err++;
                $display("FAIL b2b_op_%0d: got gap=%0d idle=%0d q=%0d r=%0d want gap=18 idle=1 q=2 r=3",
                         k, gap, idle, quotient, remainder);
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random;
        logic [15:0] a, eq; logic [7:0] b, er; logic ez;
        int lat, bc, elat;
        for (int i = 0; i < 40; i++) begin
            a = (i % 5 == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom_range(0, 65535));
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            model(a, b, eq, er, ez);
            elat = (b == 8'd0) ? 1 : 17;
            do_op(a, b, lat, bc);
            n_cmp++;
            if (quotient !== eq || remainder !== er || div_by_zero !== ez || lat !== elat) begin
                n_err++;
                $display("FAIL random_%0d a=%0d b=%0d: got q=%0d r=%0d z=%b lat=%0d want q=%0d r=%0d z=%b lat=%0d",
                         i, a, b, quotient, remainder, div_by_zero, lat, eq, er, ez, elat);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_vectors;
        test_div_zero;
        test_start_while_busy;
        test_reset_mid_run;
        test_back_to_back;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned restoring divider; the inverse of the team's 8x8->16 sequential multiplier.
- Takes a 16-bit dividend and an 8-bit divisor, and produces a 16-bit quotient and an 8-bit remainder.
- Resolves one quotient bit per clock and uses the same start/done handshake as the multiplier blocks.
- Used in datapath post-scaling, for example normalising convolution sums.

Parameters:
- DW, 16, dividend and quotient width.
- VW, 8, divisor and remainder width; VW <= DW.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset: sampled on rising clk, and reset==0 clears the block.
- start  in  1  request; sampled only in IDLE.
- A  in  DW  dividend.
- B  in  VW  divisor.
- quotient  out  DW  registered result.
- remainder  out  VW  registered result.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high in RUN and DONE.
- div_by_zero  out  1  registered flag for the last operation.

Behaviour:
- Reset: when reset==0 at a clk edge:
  - state goes to IDLE.
  - quotient, remainder, done, busy, div_by_zero and the internal counter, partial remainder and shift register all go to 0.
  - Reset has priority over everything, including mid-RUN; the in-flight operation is discarded and no done is produced.
- State IDLE: at an edge with start==1:
  - A is latched into the dividend shift register and B into the divisor register; operands are not re-sampled after this edge.
  - If B!=0: partial remainder P (VW+1 bits) is cleared, count=0, state goes to RUN.
  - If B==0: state goes straight to DONE, with quotient=all ones (2^DW-1), remainder=0, div_by_zero=1.
  - With start==0 the block stays in IDLE and all outputs hold.
- State RUN: each edge performs one restoring step:
  - P' = {P[VW-1:0], msb of dividend shift}; the dividend shift register shifts left.
  - If P' >= divisor: P = P'-divisor and a 1 is shifted into the quotient LSB.
  - Otherwise: P = P' and a 0 is shifted in.
  - count increments. On the edge where count reaches DW-1 (the DW-th step), quotient and remainder outputs load the final values, div_by_zero=0, and state goes to DONE.
- State DONE: done=1 for exactly this one cycle; at the next edge state goes to IDLE and done=0.
- Latency, B!=0: start sampled at edge E0; done is high in the cycle after edge E_DW (E16 by default), i.e. DW+1 edges after start is accepted.
- Latency, B==0: done is high in the cycle after E0.
- busy: 0 in IDLE; 1 in RUN and DONE.
- Start handling:
  - start while busy is ignored; it is not queued.
  - start held high continuously restarts a new operation on the first IDLE edge after DONE, so there is one idle cycle between operations.
- Output hold: quotient, remainder and div_by_zero change only on the final RUN edge, the B==0 IDLE edge, or reset. They hold from then until the next completion.
- Arithmetic:
  - Fully unsigned; P needs VW+1 bits to hold the shifted-in value before the compare.
  - The invariant A == quotient*B + remainder and remainder < B must hold for all B!=0.
  - No overflow is possible, since the quotient is always < 2^DW.

Test Plan:
- A=1000, B=7, start pulsed for 1 cycle -> done exactly 17 edges after acceptance, quotient=142, remainder=6, div_by_zero=0, busy high for 17 cycles.
- A=65535, B=255 -> quotient=257, remainder=0. Then A=100, B=200 -> quotient=0, remainder=100. Then A=255, B=1 -> quotient=255, remainder=0.
- A=1234, B=0 -> done in the cycle after the accepting edge, quotient=65535, remainder=0, div_by_zero=1. Next op A=10, B=3 -> quotient=3, remainder=1, div_by_zero cleared.
- Start op A=500, B=9; at RUN step 5 pulse start with A=7, B=2 and change A/B -> the second start is ignored; result is quotient=55, remainder=5.
- Start op A=500, B=9; assert reset=0 for one edge at RUN step 8 -> all outputs 0, state IDLE, no done pulse. A fresh op A=20, B=6 then yields quotient=3, remainder=2.
- start held high with A=13, B=5 -> done pulses repeat with exactly one IDLE cycle between DONE and the next RUN; every result is quotient=2, remainder=3.
